pipe_arbiter: RTL and testbench
===============================

Name: pipe_arbiter

Overview:
- Shares one `pipe` multiply datapath instance between NUM_REQ requesters.
- Arbitration is round-robin. The winner's cf/data is driven into the pipe and tagged with its requester id. The tag is tracked through the pipe's fixed 2-cycle latency, and each result is returned with that id.
- Also provides halt/drain sequencing so software can quiesce the datapath before reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, pipe data width.
- CF_W, 2, correction-factor width.
- PIPE_LAT, 2, pipe latency in cycles from i_en edge to o_data valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero).
- req_cf  in  NUM_REQ*CF_W  packed correction factors; requester i at [i*CF_W +: CF_W].
- req_data0  in  NUM_REQ*DATA_W  packed data word 0.
- req_data1  in  NUM_REQ*DATA_W  packed data word 1.
- req_mask  in  NUM_REQ  1 = requester eligible for grant.
- cfg_halt  in  1  level request to stop issuing and drain.
- halted  out  1  drain complete, pipe idle.
- pipe_en  out  1  to pipe i_en.
- pipe_cf  out  CF_W  to pipe i_cf.
- pipe_data0  out  DATA_W  to pipe i_data0.
- pipe_data1  out  DATA_W  to pipe i_data1.
- pipe_o_data0  in  DATA_W  from pipe o_data0.
- pipe_o_data1  in  DATA_W  from pipe o_data1.
- rsp_valid  out  1  result valid, single-cycle pulse, no backpressure.
- rsp_id  out  $clog2(NUM_REQ)  requester id of result.
- rsp_data0  out  DATA_W  result word 0.
- rsp_data1  out  DATA_W  result word 1.

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All registers are updated on posedge clk. The pipe shares the same clk/rst_n.
- Reset values:
  - req_ready=0, pipe_en=0, rsp_valid=0, rsp_id=0, rsp_data0/1=0, halted=0.
  - State=RUN, RR pointer=NUM_REQ-1, so requester 0 has highest priority first.
- Eligibility: requester i is eligible when req_valid[i] & req_mask[i] & (state==RUN) & !cfg_halt. cfg_halt gates grants combinationally in the same cycle.
- Grant: round-robin starting at pointer+1 and wrapping modulo NUM_REQ. req_ready is one-hot for the winner and may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept occurs when req_valid[i]&req_ready[i]. The RR pointer is updated to i at the clock edge.
- Pipe drive (combinational from the winner):
  - pipe_en = |req_ready.
  - pipe_cf/data0/data1 = the winner's fields.
  - All zero when there is no grant.
- Tag tracking: a PIPE_LAT-deep shift register of {valid, id}, loaded on accept and shifted every cycle.
- Response: when the tail stage is valid, the next edge registers rsp_valid=1, rsp_id=tag id, rsp_data=pipe_o_data.
  - Accept at edge N gives rsp_valid high in the cycle after edge N+PIPE_LAT+1, i.e. 3 cycles with defaults.
- Throughput: one accept per cycle. Back-to-back issues produce back-to-back responses in issue order.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when cfg_halt=1.
  - DRAIN -> HALTED when the tag pipe and the rsp stage are both empty.
  - DRAIN -> RUN when cfg_halt=0 (drain abandoned).
  - HALTED -> RUN when cfg_halt=0.
  - halted=1 only in HALTED and is registered.
- Simultaneous cfg_halt and a valid request: no grant is given.
- Mask change mid-stream takes effect the same cycle. Already-accepted requests always complete.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is issued for them. The pipe's internal regs are cleared by the same reset.
- PIPE_LAT is not checked at runtime and must match the pipe.

Optional Feature:
- Macro PIPE_ARB_STATS_EN.
- With the macro defined:
  - Adds input stats_clr and output grant_cnt (NUM_REQ*16).
  - Per-requester 16-bit accept counters, saturating at 16'hFFFF.
  - stats_clr is synchronous and takes priority over an increment in the same cycle. Counters reset to 0.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_arb_pkg:
  - State enum {RUN, DRAIN, HALTED}.
  - Default DATA_W/CF_W/PIPE_LAT constants.
  - Tag struct {valid, id}.
- Sub-module rr_arbiter(NUM_REQ): eligible vector in; one-hot grant and pointer register out.
- Tag shift register, FSM, muxes and response stage stay in pipe_arbiter.

Test Plan:
- Single request: req1 cf=2, data0=16'h0003, data1=16'hFFFF. Expect accept in 1 cycle, then rsp_valid 3 cycles later with rsp_id=1, rsp_data0=16'h0006, rsp_data1=16'hFFFF.
- Round-robin: all 4 req_valid held high for 8 cycles. Expect grants 0,1,2,3,0,1,2,3, responses in the same id order, one per cycle, with no gaps.
- Mask: req_mask=4'b1010 with all valid. Expect grants alternate 1,3. Requesters 0 and 2 never get req_ready.
- Drain: issue 2 requests back-to-back, then raise cfg_halt. Expect no further grants, both responses delivered, and halted=1 exactly 1 cycle after the last rsp_valid. Dropping cfg_halt gives halted=0 next cycle and grants resume.
- Boundary values: data0=16'h0000, data1=16'hFFFF, cf=3 → rsp_data unchanged. Data 16'h8001 with cf=2 → 16'h0002 (truncated).
- Reset mid-flight: assert rst_n=0 one cycle after an accept. Expect no rsp_valid afterwards and requester 0 to win the first post-reset contention.

Source files
------------

// File: rtl/pipe_arbiter_pkg.sv
// Shared types and default sizes for the pipe arbiter block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_CF_W     = 2;
    localparam int DEF_PIPE_LAT = 2;

    // Tag id is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/pipe_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starts after last winner.
// Latency: grant is combinational from elig_i; pointer updates at the edge after a grant.
// Backpressure: none of its own; elig_i must already include valid/mask/halt gating.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         elig_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] ptr_q;
    logic           found;
    int             idx;

    // Scan from ptr+1 wrapping around; first eligible requester wins.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && elig_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = idx[IDW-1:0];
            end
        end
    end

    // Eligibility already implies valid, so any grant is an accept; remember the winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NUM_REQ - 1);
        end else if (|grant_o) begin
            ptr_q <= grant_id_o;
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one multiply pipe between NUM_REQ requesters (round-robin), tags results with requester id; halt/drain FSM.
// Latency: grant combinational; response registered PIPE_LAT+1 cycles after the accept cycle. Optional: PIPE_ARB_STATS_EN.
// Backpressure: per-requester valid/ready on input; responses are single-cycle pulses with no backpressure.
module pipe_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CF_W     = DEF_CF_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*CF_W-1:0]    req_cf,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data0,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data1,
    input  logic [NUM_REQ-1:0]         req_mask,
    input  logic                       cfg_halt,
    output logic                       halted,
`ifdef PIPE_ARB_STATS_EN
    input  logic                       stats_clr,
    output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
    output logic                       pipe_en,
    output logic [CF_W-1:0]            pipe_cf,
    output logic [DATA_W-1:0]          pipe_data0,
    output logic [DATA_W-1:0]          pipe_data1,
    input  logic [DATA_W-1:0]          pipe_o_data0,
    input  logic [DATA_W-1:0]          pipe_o_data1,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_data0,
    output logic [DATA_W-1:0]          rsp_data1
);

    localparam int IDW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     win_id;
    logic               issue_ok;

    tag_t               tag_q [PIPE_LAT];
    tag_t               new_tag;
    tag_t               tail;
    logic               tags_busy;

    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [DATA_W-1:0]  rsp_data0_q;
    logic [DATA_W-1:0]  rsp_data1_q;

    // Halt blocks grants in the same cycle it is raised; reset blocks them too.
    assign issue_ok = rst_n && (state_q == RUN) && !cfg_halt;
    assign elig     = req_valid & req_mask & {NUM_REQ{issue_ok}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .elig_i     (elig),
        .grant_o    (grant),
        .grant_id_o (win_id)
    );

    assign req_ready = grant;
    assign pipe_en   = |grant;

    // Steer the winner's operands to the pipe; all zero when nobody is granted.
    always_comb begin
        pipe_cf    = '0;
        pipe_data0 = '0;
        pipe_data1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                pipe_cf    = req_cf[i*CF_W +: CF_W];
                pipe_data0 = req_data0[i*DATA_W +: DATA_W];
                pipe_data1 = req_data1[i*DATA_W +: DATA_W];
            end
        end
    end

    // Tag entering the shadow pipe this cycle.
    always_comb begin
        new_tag       = '0;
        new_tag.valid = |grant;
        new_tag.id    = TAG_ID_W'(win_id);
    end

    // Shadow of the datapath: one {valid,id} per pipe stage, advances every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail = tag_q[PIPE_LAT-1];

    // Any tag still in flight; when clear, the response stage is also empty after this edge.
    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            tags_busy = tags_busy | tag_q[i].valid;
        end
    end

    // Capture the pipe output alongside the tag that left the tail stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            rsp_valid_q <= tail.valid;
            if (tail.valid) begin
                rsp_id_q    <= tail.id[IDW-1:0];
                rsp_data0_q <= pipe_o_data0;
                rsp_data1_q <= pipe_o_data1;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data0 = rsp_data0_q;
    assign rsp_data1 = rsp_data1_q;

    // Halt/drain state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain completes once no tag is in flight, so halted rises the cycle after the last response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (cfg_halt) state_d = DRAIN;
            end
            DRAIN: begin
                if (!cfg_halt)      state_d = RUN;
                else if (!tags_busy) state_d = HALTED;
            end
            HALTED: begin
                if (!cfg_halt) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign halted = (state_q == HALTED);

`ifdef PIPE_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Per-requester accept counters; clear wins over increment, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the packed output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// Bench for pipe_arbiter with a behavioural 2-stage multiply pipe (o_data0 = data0*cf, o_data1 = data1).
// Latency: expected responses arrive 3 cycles after the accept cycle.
// Backpressure: none; stimulus queues expectations, a negedge monitor pops and compares.
module tb_pipe_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_cf;
    logic [63:0] req_data0;
    logic [63:0] req_data1;
    logic [3:0]  req_mask;
    logic        cfg_halt;
    logic        halted;
    logic        pipe_en;
    logic [1:0]  pipe_cf;
    logic [15:0] pipe_data0;
    logic [15:0] pipe_data1;
    logic [15:0] pipe_o_data0;
    logic [15:0] pipe_o_data1;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data0;
    logic [15:0] rsp_data1;

    pipe_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cf       (req_cf),
        .req_data0    (req_data0),
        .req_data1    (req_data1),
        .req_mask     (req_mask),
        .cfg_halt     (cfg_halt),
        .halted       (halted),
        .pipe_en      (pipe_en),
        .pipe_cf      (pipe_cf),
        .pipe_data0   (pipe_data0),
        .pipe_data1   (pipe_data1),
        .pipe_o_data0 (pipe_o_data0),
        .pipe_o_data1 (pipe_o_data1),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data0    (rsp_data0),
        .rsp_data1    (rsp_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural pipe: two register stages, same synchronous reset.
    logic [15:0] p1_d0, p1_d1, p2_d0, p2_d1;
    always @(posedge clk) begin
        if (!rst_n) begin
            p1_d0 <= '0; p1_d1 <= '0; p2_d0 <= '0; p2_d1 <= '0;
        end else begin
            p1_d0 <= pipe_en ? 16'(pipe_data0 * {14'd0, pipe_cf}) : 16'd0;
            p1_d1 <= pipe_en ? pipe_data1 : 16'd0;
            p2_d0 <= p1_d0;
            p2_d1 <= p1_d1;
        end
    end
    assign pipe_o_data0 = p2_d0;
    assign pipe_o_data1 = p2_d1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   acc_q[$];

    // Monitor: compare every accept against the expected grant order, every response against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
        end else begin
            chk("pipe_en", 32'(pipe_en), 32'(|(req_valid & req_ready)));
            if (|(req_valid & req_ready)) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    int g;
                    g = gnt_q.pop_front();
                    chk("grant", 32'(req_ready), 32'd1 << g);
                end
                acc_q.push_back(cyc);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, rsp_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data0", 32'(rsp_data0), 32'(e.d0));
                    chk("rsp_data1", 32'(rsp_data1), 32'(e.d1));
                    if (acc_q.size() > 0) chk("rsp_latency", 32'(cyc - acc_q.pop_front()), 32'd3);
                    else                  chk("rsp_without_accept", 32'd1, 32'd0);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] cf, input logic [15:0] d0, input logic [15:0] d1);
        req_cf[i*2 +: 2]     = cf;
        req_data0[i*16 +: 16] = d0;
        req_data1[i*16 +: 16] = d1;
    endtask

    // Single request from an idle arbiter: must be accepted in its first cycle.
    task automatic issue(input int i, input logic [1:0] cf, input logic [15:0] d0, input logic [15:0] d1);
        set_req(i, cf, d0, d1);
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        @(negedge clk);
        chk("accept_first_cycle", 32'(req_ready[i]), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Round-robin table: per requester operands and hand-computed results.
    logic [1:0]  t_cf  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] t_d0  [4] = '{16'h0010, 16'h0100, 16'h0005, 16'h1234};
    logic [15:0] t_d1  [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    logic [15:0] e_d0  [4] = '{16'h0010, 16'h0200, 16'h000F, 16'h0000};
    logic [15:0] e_d1  [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    int          mask_order [6] = '{3, 1, 3, 1, 3, 1};

    int last_rsp;
    int first_halt;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_cf    = '0;
        req_data0 = '0;
        req_data1 = '0;
        req_mask  = 4'hF;
        cfg_halt  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_pipe_en", 32'(pipe_en), 32'd0);
        chk("rst_pipe_data0", 32'(pipe_data0), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data0", 32'(rsp_data0), 32'd0);
        chk("rst_rsp_data1", 32'(rsp_data1), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Round-robin from reset pointer: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_req(i, t_cf[i], t_d0[i], t_d1[i]);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                gnt_q.push_back(i);
                exp_q.push_back('{id: 2'(i), d0: e_d0[i], d1: e_d1[i]});
            end
        end
        @(posedge clk); #1;
        req_valid = 4'hF;
        repeat (8) @(posedge clk);
        #1 req_valid = 4'h0;
        wait_idle();

        // Single request from requester 1
        gnt_q.push_back(1);
        exp_q.push_back('{id: 2'd1, d0: 16'h0006, d1: 16'hFFFF});
        issue(1, 2'd2, 16'h0003, 16'hFFFF);
        wait_idle();

        // Mask 1010: only 1 and 3 are granted, alternating
        for (int i = 0; i < 4; i++) set_req(i, t_cf[i], t_d0[i], t_d1[i]);
        for (int k = 0; k < 6; k++) begin
            gnt_q.push_back(mask_order[k]);
            exp_q.push_back('{id: 2'(mask_order[k]), d0: e_d0[mask_order[k]], d1: e_d1[mask_order[k]]});
        end
        @(posedge clk); #1;
        req_mask  = 4'b1010;
        req_valid = 4'hF;
        repeat (6) @(posedge clk);
        #1 req_valid = 4'h0;
        req_mask = 4'hF;
        wait_idle();

        // Boundary operands
        gnt_q.push_back(2);
        exp_q.push_back('{id: 2'd2, d0: 16'h0000, d1: 16'hFFFF});
        issue(2, 2'd3, 16'h0000, 16'hFFFF);
        gnt_q.push_back(0);
        exp_q.push_back('{id: 2'd0, d0: 16'h0002, d1: 16'h1234});
        issue(0, 2'd2, 16'h8001, 16'h1234);
        wait_idle();

        // Drain: two back-to-back issues, then halt while requests stay valid
        set_req(1, 2'd1, 16'h00AA, 16'h0001);
        set_req(2, 2'd2, 16'h4000, 16'h0002);
        gnt_q.push_back(1);
        gnt_q.push_back(2);
        exp_q.push_back('{id: 2'd1, d0: 16'h00AA, d1: 16'h0001});
        exp_q.push_back('{id: 2'd2, d0: 16'h8000, d1: 16'h0002});
        @(posedge clk); #1;
        req_valid = 4'b0110;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_halt   = 1'b1;
        last_rsp   = -100;
        first_halt = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) last_rsp = cyc;
            if (halted) begin
                first_halt = cyc;
                break;
            end
        end
        chk("halted_reached", 32'(first_halt >= 0), 32'd1);
        chk("halted_after_last_rsp", 32'(first_halt - last_rsp), 32'd1);
        chk("drain_rsp_all_seen", 32'(exp_q.size()), 32'd0);
        gnt_q.push_back(1);
        exp_q.push_back('{id: 2'd1, d0: 16'h00AA, d1: 16'h0001});
        @(posedge clk); #1;
        cfg_halt = 1'b0;
        @(negedge clk);
        chk("halted_hold", 32'(halted), 32'd1);
        chk("no_grant_while_halted", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halted_release", 32'(halted), 32'd0);
        chk("resume_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = 4'h0;
        wait_idle();

        // Reset one cycle after an accept: no response, pointer back to reset value
        gnt_q.push_back(3);
        issue(3, 2'd1, 16'h0077, 16'h0055);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        set_req(0, 2'd1, 16'h0010, 16'hA000);
        for (int i = 1; i < 4; i++) set_req(i, t_cf[i], t_d0[i], t_d1[i]);
        gnt_q.push_back(0);
        exp_q.push_back('{id: 2'd0, d0: 16'h0010, d1: 16'hA000});
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(posedge clk); #1;
        req_valid = 4'h0;
        wait_idle();
        repeat (5) @(negedge clk);

        chk("leftover_rsp", 32'(exp_q.size()), 32'd0);
        chk("leftover_grant", 32'(gnt_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
